// File: rtl/serial_link_pkg.sv
`default_nettype none
// ============================================================================
// Package     : serial_link_pkg
// Description : Shared definitions for both ends of the serial shift link
//               (serializer and deserializer): receiver state encoding and
//               the bit-order constants.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_link_pkg;

   // Receiver state: IDLE waits for the first bit of a word, RECV collects
   // the remaining bits.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } link_state_e;

   // Bit order on the wire. MSB-first matches the serializer's shift-left
   // mode and LSB-first matches its shift-right mode.
   localparam logic ORD_LSB_FIRST = 1'b0;
   localparam logic ORD_MSB_FIRST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_word_rx_if.sv
`default_nettype none
// ============================================================================
// Interface   : serial_word_rx_if
// Description : Serial input stream and parallel word output of the
//               serial_word_rx receiver.
//               Serial side : sin, sin_valid, sof, msb_first
//               Word side   : pout, pout_valid, pout_ready
//               Status      : busy, overrun, frame_err
//               master = producer/consumer side, slave = receiver side.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_word_rx_if #(
   parameter int W = 8
);
   logic         sin;
   logic         sin_valid;
   logic         sof;
   logic         msb_first;
   logic [W-1:0] pout;
   logic         pout_valid;
   logic         pout_ready;
   logic         busy;
   logic         overrun;
   logic         frame_err;

   modport master (
      output sin, sin_valid, sof, msb_first, pout_ready,
      input  pout, pout_valid, busy, overrun, frame_err
   );

   modport slave (
      input  sin, sin_valid, sof, msb_first, pout_ready,
      output pout, pout_valid, busy, overrun, frame_err
   );
endinterface
`default_nettype wire

// File: rtl/serial_word_rx_shift_core.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shift_core
// Description : W-bit serial-in/parallel-out shift register.
//               clk, rst    : clock, synchronous active-high reset
//               en          : shift one bit in this edge
//               clr         : discard current contents (with en, the new
//                             bit shifts into an all-zero register)
//               msb_first   : 1 = shift toward MSB (din enters at bit 0),
//                             0 = shift toward LSB (din enters at bit W-1)
//               din         : serial bit
//               q           : current register contents
//               shifted     : value q takes if en is asserted this edge
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift_core #(
   parameter int W = 8
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         en,
   input  wire logic         clr,
   input  wire logic         msb_first,
   input  wire logic         din,
   output logic      [W-1:0] q,
   output logic      [W-1:0] shifted
);
   import serial_link_pkg::*;

   logic [W-1:0] base;

   always_comb begin
      base = clr ? '0 : q;
      if (msb_first == ORD_MSB_FIRST) begin
         shifted = {base[W-2:0], din};
      end else begin
         shifted = {din, base[W-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= shifted;
      end else if (clr) begin
         q <= '0;
      end
   end
endmodule
`default_nettype wire

// File: rtl/serial_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_rx
// Description : Deserializes a bit-strobed serial stream into W-bit words
//               with per-word selectable bit order, a valid/ready output
//               holding register, and overrun / framing-error pulses.
//               clk, rst : clock, synchronous active-high reset
//               link     : serial_word_rx_if.slave (serial in, word out,
//                          status flags)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_rx #(
   parameter int W           = 8,
   parameter bit REQUIRE_SOF = 1'b1
) (
   input  wire logic            clk,
   input  wire logic            rst,
   serial_word_rx_if.slave      link
);
   import serial_link_pkg::*;

   localparam int         CW     = $clog2(W + 1);
   localparam logic [0:0] S_IDLE = IDLE;
   localparam logic [0:0] S_RECV = RECV;

   logic [0:0]    state;
   logic [CW-1:0] bit_cnt;
   logic          ord;

   logic          in_recv;
   logic          start;
   logic          restart;
   logic          shift_en;
   logic          done;
   logic          dir;
   logic [W-1:0]  sreg;
   logic [W-1:0]  sreg_next;

   always_comb begin
      in_recv  = (state == S_RECV);
      // A sof bit always begins a fresh word, even mid-word.
      start    = link.sin_valid &&
                 (link.sof || (!in_recv && !REQUIRE_SOF));
      restart  = link.sin_valid && in_recv && link.sof;
      shift_en = link.sin_valid && (start || in_recv);
      done     = link.sin_valid && in_recv && !link.sof &&
                 (bit_cnt == CW'(W - 1));
      // The first bit of a word uses the order presented with it.
      dir      = start ? link.msb_first : ord;
   end

   sipo_shift_core #(
      .W (W)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .en        (shift_en),
      .clr       (start),
      .msb_first (dir),
      .din       (link.sin),
      .q         (sreg),
      .shifted   (sreg_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         ord     <= ORD_LSB_FIRST;
      end else if (start) begin
         state   <= S_RECV;
         bit_cnt <= CW'(1);
         ord     <= link.msb_first;
      end else if (done) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
      end else if (shift_en) begin
         bit_cnt <= bit_cnt + CW'(1);
      end
   end

   // The completed word is taken from the shifter's next value so it lands
   // on pout at the same edge that samples the last bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         link.pout       <= '0;
         link.pout_valid <= 1'b0;
         link.overrun    <= 1'b0;
         link.frame_err  <= 1'b0;
      end else begin
         link.overrun   <= 1'b0;
         link.frame_err <= restart;
         if (done) begin
            if (!link.pout_valid || link.pout_ready) begin
               link.pout       <= sreg_next;
               link.pout_valid <= 1'b1;
            end else begin
               link.overrun    <= 1'b1;
            end
         end else if (link.pout_valid && link.pout_ready) begin
            link.pout_valid <= 1'b0;
         end
      end
   end

   assign link.busy = in_recv;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_rx
// Description : Self-checking bench for serial_word_rx (W = 8, sof required).
//               A bit-list reference model rebuilds each word from the
//               received bits and the latched order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_rx;
   localparam int W = 8;
   localparam bit REQUIRE_SOF = 1'b1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   serial_word_rx_if #(.W(W)) bus ();

   serial_word_rx #(
      .W           (W),
      .REQUIRE_SOF (REQUIRE_SOF)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .link (bus.slave)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Reference model state
   logic         m_bits[$];
   bit           m_busy  = 1'b0;
   bit           m_ord   = 1'b0;
   logic [W-1:0] m_pout  = '0;
   bit           m_valid = 1'b0;
   bit           m_ov    = 1'b0;
   bit           m_fe    = 1'b0;

   function automatic logic [W+3:0] obs_vec();
      return {bus.pout, bus.pout_valid, bus.busy, bus.overrun, bus.frame_err};
   endfunction

   function automatic logic [W+3:0] exp_vec();
      return {m_pout, m_valid, m_busy, m_ov, m_fe};
   endfunction

   // Bit i of a word in transmission order.
   function automatic logic tx_bit(input logic [W-1:0] val, input bit msb, input int i);
      return msb ? val[W-1-i] : val[i];
   endfunction

   // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
   task automatic step(input logic s, input logic v, input logic f,
                       input logic m, input logic r, input logic rs);
      logic [W-1:0] word;
      bit           complete;
      bus.sin = s; bus.sin_valid = v; bus.sof = f;
      bus.msb_first = m; bus.pout_ready = r; rst = rs;
      word = '0;
      complete = 1'b0;
      m_ov = 1'b0;
      m_fe = 1'b0;
      if (rs) begin
         m_bits.delete();
         m_busy = 1'b0; m_ord = 1'b0; m_pout = '0; m_valid = 1'b0;
      end else begin
         if (v) begin
            if (f && m_busy) m_fe = 1'b1;
            if (f || (!m_busy && !REQUIRE_SOF)) begin
               m_bits.delete();
               m_bits.push_back(s);
               m_ord  = m;
               m_busy = 1'b1;
            end else if (m_busy) begin
               m_bits.push_back(s);
               if (m_bits.size() == W) begin
                  for (int i = 0; i < W; i++)
                     word[m_ord ? (W-1-i) : i] = m_bits[i];
                  complete = 1'b1;
                  m_busy = 1'b0;
                  m_bits.delete();
               end
            end
         end
         if (complete) begin
            if (!m_valid || r) begin
               m_pout = word; m_valid = 1'b1;
            end else begin
               m_ov = 1'b1;
            end
         end else if (m_valid && r) begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (obs_vec() !== '0) begin
         errors++;
         $display("FAIL reset: got %h expected %h", obs_vec(), {(W+4){1'b0}});
      end
   endtask

   task automatic test_lsb_a5();
      logic [W-1:0] val = 8'hA5;
      for (int i = 0; i < W; i++) begin
         step(tx_bit(val, 1'b0, i), 1'b1, (i == 0), 1'b0, 1'b1, 1'b0);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL lsb_a5 bit %0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      vectors++;
      if (bus.pout !== 8'hA5 || bus.pout_valid !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL lsb_a5 word: got pout=%h v=%b busy=%b expected a5 1 0",
                  bus.pout, bus.pout_valid, bus.busy);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec() || bus.pout_valid !== 1'b0) begin
         errors++;
         $display("FAIL lsb_a5 consume: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_msb_gaps();
      logic [W-1:0] val = 8'h3C;
      for (int i = 0; i < 2*W; i++) begin
         if (i % 2 == 0)
            step(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
         else
            step(tx_bit(val, 1'b1, i/2), 1'b1, (i == 1), 1'b1, 1'b1, 1'b0);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL msb_gaps cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      vectors++;
      if (bus.pout !== 8'h3C || bus.pout_valid !== 1'b1) begin
         errors++;
         $display("FAIL msb_gaps word: got pout=%h v=%b expected 3c 1", bus.pout, bus.pout_valid);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] words[2] = '{8'h11, 8'h22};
      int ov_seen = 0;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < W; i++) begin
            step(tx_bit(words[w], 1'b0, i), 1'b1, (i == 0), 1'b0, 1'b0, 1'b0);
            if (bus.overrun === 1'b1) ov_seen++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL backpressure w%0d b%0d: got %h expected %h", w, i, obs_vec(), exp_vec());
            end
         end
      end
      vectors++;
      if (bus.pout !== 8'h11 || ov_seen != 1) begin
         errors++;
         $display("FAIL backpressure hold: got pout=%h overruns=%0d expected 11 1", bus.pout, ov_seen);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (bus.pout_valid !== 1'b0 || bus.pout !== 8'h11 || bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL backpressure release: got pout=%h v=%b ov=%b expected 11 0 0",
                  bus.pout, bus.pout_valid, bus.overrun);
      end
   endtask

   task automatic test_simul_consume();
      logic [W-1:0] words[2] = '{8'h11, 8'h22};
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < W; i++) begin
            step(tx_bit(words[w], 1'b0, i), 1'b1, (i == 0), 1'b0,
                 (w == 1 && i == W-1), 1'b0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL simul w%0d b%0d: got %h expected %h", w, i, obs_vec(), exp_vec());
            end
         end
      end
      vectors++;
      if (bus.pout !== 8'h22 || bus.pout_valid !== 1'b1 || bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL simul word: got pout=%h v=%b ov=%b expected 22 1 0",
                  bus.pout, bus.pout_valid, bus.overrun);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_frame_err();
      logic [W-1:0] val = 8'h96;
      int fe_seen = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'($urandom), 1'b1, (i == 0), 1'b0, 1'b1, 1'b0);
         if (bus.frame_err === 1'b1) fe_seen++;
      end
      for (int i = 0; i < W; i++) begin
         step(tx_bit(val, 1'b1, i), 1'b1, (i == 0), 1'b1, 1'b0, 1'b0);
         if (bus.frame_err === 1'b1) fe_seen++;
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL frame b%0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      // Bits without sof while idle must not start a word.
      for (int i = 0; i < 3; i++) begin
         step(1'($urandom), 1'b1, 1'b0, 1'($urandom), 1'b0, 1'b0);
         vectors++;
         if (obs_vec() !== exp_vec() || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL frame idle %0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      vectors++;
      if (bus.pout !== 8'h96 || fe_seen != 1) begin
         errors++;
         $display("FAIL frame word: got pout=%h fe_pulses=%0d expected 96 1", bus.pout, fe_seen);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_rst_mid();
      logic [W-1:0] val = 8'h0F;
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (obs_vec() !== '0) begin
         errors++;
         $display("FAIL rst_mid clear: got %h expected %h", obs_vec(), {(W+4){1'b0}});
      end
      for (int i = 0; i < W; i++)
         step(tx_bit(val, 1'b0, i), 1'b1, (i == 0), 1'b0, 1'b0, 1'b0);
      vectors++;
      if (bus.pout !== 8'h0F || bus.pout_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL rst_mid word: got %h expected %h", obs_vec(), exp_vec());
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(11) == 0),
              1'($urandom), 1'($urandom), ($urandom_range(149) == 0));
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.sof = 1'b0;
      bus.msb_first = 1'b0; bus.pout_ready = 1'b0;
      test_reset();
      test_lsb_a5();
      test_msb_gaps();
      test_backpressure();
      test_simul_consume();
      test_frame_err();
      test_rst_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
`default_nettype wire
